// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, memory W_R encoding and default widths for mem_arbiter.
package mem_arb_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 4;
    localparam int TIMEOUT_DEF = 4;
    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; the pointer names the requester with priority.
module rr_arbiter_2 (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;
    assign gnt_o = (req_i == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_i;
    // granting A hands priority to B and vice versa
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ptr_q <= 1'b0;
        else if (upd_i) ptr_q <= gnt_o[0];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters onto a single-port memory with one-cycle read latency
// and a bounded read wait that reports a timeout through rsp_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_wr,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                mem_en,
    output logic                mem_w_r,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_valid
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e              state_q, state_d;
    logic                owner_q, mem_w_r_q, err_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q, rdata_q;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          gnt;
    logic                hs, sel, timeout;
    rr_arbiter_2 u_rr (.CLK(CLK), .RST_n(RST_n), .req_i(req_valid), .upd_i(hs), .gnt_o(gnt));
    assign req_ready = (state_q == IDLE && RST_n) ? gnt : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign sel       = gnt[1];
    assign timeout   = cnt_q == CW'(TIMEOUT - 1);
    always_comb begin
        state_d = (state_q == IDLE)    ? (hs ? ISSUE : IDLE) :
                  (state_q == ISSUE)   ? ((mem_w_r_q == WRITE) ? RESP : WAIT_RD) :
                  (state_q == WAIT_RD) ? ((mem_valid || timeout) ? RESP : WAIT_RD) : IDLE;
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            mem_w_r_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                owner_q     <= sel;
                mem_w_r_q   <= req_wr[sel] ? WRITE : READ;
                mem_addr_q  <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                mem_wdata_q <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                rdata_q     <= '0;
                err_q       <= 1'b0;
                cnt_q       <= '0;
            end
            if (state_q == WAIT_RD) begin
                if (mem_valid) rdata_q <= mem_rdata;
                else if (timeout) err_q <= 1'b1;
                else cnt_q <= cnt_q + CW'(1);
            end
        end
    end
    assign mem_en    = state_q == ISSUE;
    assign mem_w_r   = mem_w_r_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, read/write latency, timeout and mid-transaction reset.
module tb_mem_arbiter;
    logic        CLK = 1'b0, RST_n = 1'b0;
    logic [1:0]  req_valid = '0, req_wr = '0, req_ready, rsp_valid;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata = '0;
    logic        rsp_err, mem_en, mem_w_r, mem_valid = 1'b0, stall = 1'b0, prev_en = 1'b0;
    logic [3:0]  mem_addr;
    logic [31:0] mem [16];
    int total = 0, bad = 0;

    mem_arbiter dut (
        .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 CLK = ~CLK;

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    always @(posedge CLK) begin
        mem_valid <= mem_en && mem_w_r && !stall;
        if (mem_en && mem_w_r) mem_rdata <= mem[mem_addr];
        if (mem_en && !mem_w_r) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_n && mem_en) chk("mem_en_back_to_back", 64'(prev_en), 64'(0));
        prev_en = mem_en;
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
        chk({tag, "_mem_w_r"}, 64'(mem_w_r), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    task automatic do_req(input string tag, input int idx, input logic wr, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat);
        int n;
        @(negedge CLK);
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_wr[idx] = wr;
        req_addr[idx*4 +: 4] = addr;
        req_wdata[idx*32 +: 32] = wd;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(2'b01 << idx));
        @(negedge CLK);
        req_valid = '0;
        n = 1;
        while (rsp_valid === 2'b00 && n < 12) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(2'b01 << idx));
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    endtask

    initial begin
        int n;
        int exp_g [4] = '{0, 1, 0, 1};
        repeat (2) @(negedge CLK);
        chk_quiet("reset");
        // both requesters write continuously: A to addr 1, B to addr 2
        RST_n = 1'b1;
        req_wr = 2'b11;
        req_addr = {4'd2, 4'd1};
        req_wdata = {32'h0000_0022, 32'h0000_0011};
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            #1;
            while (req_ready === 2'b00 && n < 20) begin
                @(negedge CLK);
                #1;
                n++;
            end
            chk("rr_grant", 64'(req_ready), 64'(2'b01 << exp_g[g]));
            @(negedge CLK);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge CLK);
        do_req("a_wr3", 0, 1'b1, 4'd3, 32'hA5A5_0001, 32'h0, 1'b0, 2);
        do_req("a_rd3", 0, 1'b0, 4'd3, 32'h0, 32'hA5A5_0001, 1'b0, 3);
        do_req("a_rd1", 0, 1'b0, 4'd1, 32'h0, 32'h0000_0011, 1'b0, 3);
        do_req("b_rd2", 1, 1'b0, 4'd2, 32'h0, 32'h0000_0022, 1'b0, 3);
        do_req("b_wr15", 1, 1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0, 1'b0, 2);
        do_req("a_rd15", 0, 1'b0, 4'd15, 32'h0, 32'hFFFF_FFFF, 1'b0, 3);
        do_req("a_rd0", 0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 3);
        stall = 1'b1;
        do_req("a_timeout", 0, 1'b0, 4'd3, 32'h0, 32'h0, 1'b1, 6);
        // A starts a stalled read, reset lands while it waits for memory
        @(negedge CLK);
        req_valid = 2'b01;
        req_wr = 2'b00;
        req_addr = {4'd3, 4'd3};
        @(negedge CLK);
        req_valid = 2'b00;
        chk("abort_in_issue", 64'(mem_en), 64'(1));
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        chk_quiet("abort");
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
        end
        stall = 1'b0;
        RST_n = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("post_reset_a_first", 64'(req_ready), 64'(2'b01));
        req_valid = 2'b00;
        do_req("resume_rd3", 0, 1'b0, 4'd3, 32'h0, 32'hA5A5_0001, 1'b0, 3);
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
